// File: rtl/level_burst_gen.sv
// -----------------------------------------------------------------------------
// level_burst_gen
//
// Purpose:
//    Emits a burst of single-cycle level highs, separated by a programmable
//    low gap. The burst is launched through a start/busy/done handshake.
//    The block also counts the highs modulo MOD, so that a downstream
//    level-counting FSM can be driven and cross-checked in the same design.
//
// Ports:
//    clk        in   rising-edge clock
//    reset      in   asynchronous, active-high reset
//    start      in   request a burst; sampled only in IDLE
//    abort      in   synchronous abort of a running burst
//    num_highs  in   [CNT_W] number of high cycles; latched on an accepted start
//    gap_len    in   [GAP_W] low cycles between highs; latched on an accepted start
//    level      out  generated level stream
//    wrap       out  high during the high cycle that completes a group of MOD highs
//    groups     out  [CNT_W] completed MOD-groups in the current or last burst
//    busy       out  high in any state other than IDLE
//    done       out  one-cycle pulse on normal completion
// -----------------------------------------------------------------------------
module level_burst_gen #(
   parameter int CNT_W = 8,
   parameter int GAP_W = 4,
   parameter int MOD   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_highs,
   input  logic [GAP_W-1:0] gap_len,
   output logic             level,
   output logic             wrap,
   output logic [CNT_W-1:0] groups,
   output logic             busy,
   output logic             done
);

   // The phase counter wraps at MOD, so it only needs enough bits for MOD-1.
   localparam int PH_W = (MOD > 2) ? $clog2(MOD) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(MOD - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      GAP  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t           state_q,      state_d;
   logic [CNT_W-1:0] remaining_q,  remaining_d;
   logic [GAP_W-1:0] gap_cnt_q,    gap_cnt_d;
   logic [GAP_W-1:0] gap_reload_q, gap_reload_d;
   logic [PH_W-1:0]  phase_q,      phase_d;
   logic [CNT_W-1:0] groups_q,     groups_d;

   logic wrap_hit;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: every flop here, the gap reload included, is reset asynchronously.
   // The reset therefore drops level and busy at once, with no wait for a clock edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         remaining_q  <= '0;
         gap_cnt_q    <= '0;
         gap_reload_q <= '0;
         phase_q      <= '0;
         groups_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments. All flops sample the values from
         // before the edge, whatever order the statements appear in.
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         gap_cnt_q    <= gap_cnt_d;
         gap_reload_q <= gap_reload_d;
         phase_q      <= phase_d;
         groups_q     <= groups_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: the first thing this block does is give every *_d a hold value.
      // A branch that skips a signal then cannot infer a latch.
      state_d      = state_q;
      remaining_d  = remaining_q;
      gap_cnt_d    = gap_cnt_q;
      gap_reload_d = gap_reload_q;
      phase_d      = phase_q;
      groups_d     = groups_q;

      unique case (state_q)
         IDLE: begin
            // If start and abort arrive together, start wins. Abort has no
            // effect in IDLE.
            if (start) begin
               remaining_d  = num_highs;
               gap_reload_d = gap_len;
               phase_d      = '0;
               groups_d     = '0;
               state_d      = (num_highs != '0) ? HIGH : DONE;
            end
         end

         HIGH: begin
            // A high that has been emitted is counted, including one that is
            // aborted. This keeps groups consistent with any wrap that was seen.
            remaining_d = remaining_q - CNT_W'(1);
            if (wrap_hit) begin
               phase_d  = '0;
               groups_d = groups_q + CNT_W'(1);
            end else begin
               phase_d  = phase_q + PH_W'(1);
            end

            if (abort) begin
               state_d = IDLE;
            end else if (remaining_q == CNT_W'(1)) begin
               state_d = DONE;               // the last high has no trailing gap
            end else if (gap_reload_q == '0) begin
               state_d = HIGH;               // contiguous highs
            end else begin
               state_d   = GAP;
               gap_cnt_d = gap_reload_q;
            end
         end

         GAP: begin
            gap_cnt_d = gap_cnt_q - GAP_W'(1);
            if (abort) begin
               state_d = IDLE;
            end else if (gap_cnt_q == GAP_W'(1)) begin
               state_d = HIGH;
            end
         end

         DONE: begin
            state_d = IDLE;                  // an abort here also lands in IDLE
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs are decoded from the state register and the phase counter only
   // ---------------------------------------------------------------------------
   always_comb begin
      wrap_hit = (state_q == HIGH) && (phase_q == PH_LAST);
      level    = (state_q == HIGH);
      busy     = (state_q != IDLE);
      done     = (state_q == DONE);
      wrap     = wrap_hit;
      groups   = groups_q;
   end

endmodule

// File: tb/tb_level_burst_gen.sv
// -----------------------------------------------------------------------------
// tb_level_burst_gen
//
// Directed bench for level_burst_gen. Each step drives the inputs #1 after a
// rising edge. It then compares the outputs for that cycle against
// hand-computed expectations. Cycle 0 is the cycle in which start is presented.
// -----------------------------------------------------------------------------
module tb_level_burst_gen;

   localparam int CNT_W = 8;
   localparam int GAP_W = 4;
   localparam int MOD   = 5;

   logic             clk;
   logic             reset;
   logic             start;
   logic             abort;
   logic [CNT_W-1:0] num_highs;
   logic [GAP_W-1:0] gap_len;
   logic             level;
   logic             wrap;
   logic [CNT_W-1:0] groups;
   logic             busy;
   logic             done;

   int n_checks = 0;
   int n_errors = 0;

   level_burst_gen #(
      .CNT_W(CNT_W),
      .GAP_W(GAP_W),
      .MOD  (MOD)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .abort    (abort),
      .num_highs(num_highs),
      .gap_len  (gap_len),
      .level    (level),
      .wrap     (wrap),
      .groups   (groups),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int cyc,
                          input logic l, input logic w, input logic b, input logic d);
      chk($sformatf("%s c%0d level", tag, cyc), {31'b0, level}, {31'b0, l});
      chk($sformatf("%s c%0d wrap",  tag, cyc), {31'b0, wrap},  {31'b0, w});
      chk($sformatf("%s c%0d busy",  tag, cyc), {31'b0, busy},  {31'b0, b});
      chk($sformatf("%s c%0d done",  tag, cyc), {31'b0, done},  {31'b0, d});
   endtask

   task automatic chk_groups(input string tag, input int exp);
      chk($sformatf("%s groups", tag), {24'b0, groups}, exp);
   endtask

   // Move to the next cycle. Inputs change and outputs are sampled 1 time
   // unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      num_highs = '0;
      gap_len   = '0;

      // ---------------- reset state ----------------
      #2;
      chk_out("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_groups("reset", 0);
      tick();
      tick();
      reset = 1'b0;
      tick();
      chk_out("post_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- 1: contiguous burst, 7 highs ----------------
      num_highs = 8'd7;
      gap_len   = 4'd0;
      start     = 1'b1;
      chk_out("t1", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int c = 1; c <= 9; c++) begin
         tick();
         start = 1'b0;
         chk_out("t1", c, (c >= 1 && c <= 7), (c == 5), (c <= 8), (c == 8));
      end
      chk_groups("t1", 1);

      // ---------------- 2: gapped burst, 3 highs, gap 2 ----------------
      num_highs = 8'd3;
      gap_len   = 4'd2;
      start     = 1'b1;
      for (int c = 1; c <= 9; c++) begin
         tick();
         start = 1'b0;
         chk_out("t2", c, (c == 1 || c == 4 || c == 7), 1'b0, (c <= 8), (c == 8));
      end
      chk_groups("t2", 0);

      // ---------------- 3: zero count ----------------
      num_highs = 8'd0;
      gap_len   = 4'd3;
      start     = 1'b1;
      for (int c = 1; c <= 2; c++) begin
         tick();
         start = 1'b0;
         chk_out("t3", c, 1'b0, 1'b0, (c == 1), (c == 1));
      end
      chk_groups("t3", 0);

      // ---------------- 4: multi-wrap, 10 highs, gap 1 ----------------
      num_highs = 8'd10;
      gap_len   = 4'd1;
      start     = 1'b1;
      for (int c = 1; c <= 21; c++) begin
         tick();
         start = 1'b0;
         chk_out("t4", c, (c <= 19 && (c % 2) == 1), (c == 9 || c == 19),
                 (c <= 20), (c == 20));
         if (c == 10) chk_groups("t4 mid", 1);
      end
      chk_groups("t4", 2);

      // ---------------- 5: abort, ignored start, start+abort ----------------
      num_highs = 8'd7;
      gap_len   = 4'd0;
      start     = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         tick();
         start = 1'b0;
         abort = 1'b0;
         if (c == 3) begin
            // While busy, this start and the new fields must be ignored.
            start     = 1'b1;
            num_highs = 8'd2;
            gap_len   = 4'd5;
         end
         if (c == 6) abort = 1'b1;
         chk_out("t5", c, (c <= 6), (c == 5), (c <= 6), 1'b0);
      end
      chk_groups("t5", 1);

      // In IDLE, start and abort together: start wins.
      num_highs = 8'd1;
      gap_len   = 4'd0;
      start     = 1'b1;
      abort     = 1'b1;
      tick();
      start = 1'b0;
      abort = 1'b0;
      chk_out("t5b", 1, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_groups("t5b cleared", 0);
      tick();
      chk_out("t5b", 2, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk_out("t5b", 3, 1'b0, 1'b0, 1'b0, 1'b0);

      // ---------------- 6: reset mid-burst ----------------
      num_highs = 8'd7;
      gap_len   = 4'd0;
      start     = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         tick();
         start = 1'b0;
      end
      chk_out("t6 pre", 6, 1'b1, 1'b0, 1'b1, 1'b0);
      chk_groups("t6 pre", 1);
      #2;
      reset = 1'b1;
      #1;
      chk_out("t6 async", 6, 1'b0, 1'b0, 1'b0, 1'b0);
      chk_groups("t6 async", 0);
      tick();
      #2;
      reset = 1'b0;
      tick();
      chk_out("t6 idle", 0, 1'b0, 1'b0, 1'b0, 1'b0);
      num_highs = 8'd2;
      gap_len   = 4'd0;
      start     = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         tick();
         start = 1'b0;
         chk_out("t6 after", c, (c <= 2), 1'b0, (c <= 3), (c == 3));
      end
      chk_groups("t6 after", 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
